// File: rtl/constants.sv
// Shared fetch-stage constants.
//   PC_IF  : next sequential PC from the fetch incrementer
//   PC_EX  : branch / JAL target computed in EX
//   PC_REG : JALR target (register + offset) from EX
package constants;
  localparam logic [1:0] PC_IF  = 2'd0;
  localparam logic [1:0] PC_EX  = 2'd1;
  localparam logic [1:0] PC_REG = 2'd2;
endpackage

// File: rtl/pc_flow_pkg.sv
// Types and widths shared by the PC sequencing controller and its
// performance counters.
package pc_flow_pkg;
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam int STALL_CNT_W = 8;
  localparam int PERF_CNT_W  = 32;
endpackage

// File: rtl/pc_flow_perf.sv
// Free-running performance counters for the PC sequencing controller.
// Both counters wrap naturally and clear on synchronous reset.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   i_stall           count one PC-frozen RUN cycle
//   i_redirect        count one taken redirect
//   o_stall_cycles    accumulated stall cycles
//   o_redirects       accumulated redirects
module pc_flow_perf
  import pc_flow_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_stall,
  input  logic                  i_redirect,
  output logic [PERF_CNT_W-1:0] o_stall_cycles,
  output logic [PERF_CNT_W-1:0] o_redirects
);
  logic [PERF_CNT_W-1:0] r_stall_cycles;
  logic [PERF_CNT_W-1:0] r_redirects;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_redirects    <= '0;
    end else begin
      if (i_stall)    r_stall_cycles <= r_stall_cycles + PERF_CNT_W'(1);
      if (i_redirect) r_redirects    <= r_redirects + PERF_CNT_W'(1);
    end
  end

  assign o_stall_cycles = r_stall_cycles;
  assign o_redirects    = r_redirects;
endmodule

// File: rtl/pc_flow_ctrl.sv
// Fetch-stage PC sequencing controller. Each cycle decides whether the PC
// advances, holds or redirects, and generates IF/ID and ID/EX flush/stall
// strobes. Outputs are decoded combinationally from state and inputs.
// Optional build macro: PC_FLOW_CTRL_PERF_EN enables the perf counters;
// when undefined the perf outputs are tied to zero.
// Parameters:
//   BOOT_CYCLES    cycles after reset with PC frozen and pipeline flushed
//   STALL_TIMEOUT  consecutive imem-not-ready cycles before fatal halt (1..255)
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   branch_taken_ex, jal_ex,
//   jalr_ex, halt_ex            EX-stage resolution
//   load_use                    ID load-use hazard
//   imem_ready                  instruction memory data valid
//   pc_mux, pc_en               PC select code and update enable
//   fetch_valid                 IF/ID receives a valid instruction
//   stall_if_id, flush_if_id,
//   flush_id_ex                 pipeline register control
//   halted, timeout_err         halt status (timeout_err sticky)
//   perf_stall_cycles,
//   perf_redirects              optional performance counters
module pc_flow_ctrl
  import pc_flow_pkg::*;
  import constants::*;
#(
  parameter int unsigned BOOT_CYCLES   = 4,
  parameter int unsigned STALL_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  branch_taken_ex,
  input  logic                  jal_ex,
  input  logic                  jalr_ex,
  input  logic                  halt_ex,
  input  logic                  load_use,
  input  logic                  imem_ready,
  output logic [1:0]            pc_mux,
  output logic                  pc_en,
  output logic                  fetch_valid,
  output logic                  stall_if_id,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic                  halted,
  output logic                  timeout_err,
  output logic [PERF_CNT_W-1:0] perf_stall_cycles,
  output logic [PERF_CNT_W-1:0] perf_redirects
);
  localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BOOT_W-1:0]      BOOT_LAST   = BOOT_W'(BOOT_CYCLES - 1);
  localparam logic [STALL_CNT_W-1:0] STALL_LIMIT = STALL_CNT_W'(STALL_TIMEOUT);

  state_e                 r_state;
  logic [BOOT_W-1:0]      r_boot_cnt;
  logic [STALL_CNT_W-1:0] r_stall_cnt;
  logic                   r_timeout_err;

  state_e                 w_state_nxt;
  logic [STALL_CNT_W-1:0] w_stall_cnt_nxt;
  logic                   w_timeout_set;
  logic                   w_redirect;

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis infers latches.
  always_comb begin
    pc_mux          = PC_IF;
    pc_en           = 1'b0;
    fetch_valid     = 1'b0;
    stall_if_id     = 1'b0;
    flush_if_id     = 1'b0;
    flush_id_ex     = 1'b0;
    halted          = 1'b0;
    w_state_nxt     = r_state;
    w_stall_cnt_nxt = r_stall_cnt;
    w_timeout_set   = 1'b0;
    w_redirect      = 1'b0;

    case (r_state)
      ST_BOOT: begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        if (r_boot_cnt == BOOT_LAST) w_state_nxt = ST_RUN;
      end

      ST_RUN: begin
        if (halt_ex) begin
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          w_state_nxt = ST_HALT;
        end else if (jalr_ex || branch_taken_ex || jal_ex) begin
          // A redirect discards any pending stall: the stalled fetch is on
          // the wrong path anyway.
          pc_mux      = jalr_ex ? PC_REG : PC_EX;
          pc_en       = 1'b1;
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          w_redirect  = 1'b1;
        end else if (load_use) begin
          stall_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end else if (!imem_ready) begin
          stall_if_id     = 1'b1;
          w_stall_cnt_nxt = r_stall_cnt + STALL_CNT_W'(1);
          if (w_stall_cnt_nxt == STALL_LIMIT) begin
            w_timeout_set = 1'b1;
            w_state_nxt   = ST_HALT;
          end
        end else begin
          pc_en       = 1'b1;
          fetch_valid = 1'b1;
        end

        if (imem_ready || w_redirect) w_stall_cnt_nxt = '0;
      end

      ST_HALT: begin
        halted      = 1'b1;
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end

      default: begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_BOOT;
      r_boot_cnt    <= '0;
      r_stall_cnt   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
      if (r_state == ST_BOOT) r_boot_cnt <= r_boot_cnt + BOOT_W'(1);
      if (w_timeout_set)      r_timeout_err <= 1'b1;
    end
  end

  assign timeout_err = r_timeout_err;

`ifdef PC_FLOW_CTRL_PERF_EN
  logic w_perf_stall;
  assign w_perf_stall = (r_state == ST_RUN) && !pc_en && !halt_ex;

  pc_flow_perf u_perf (
    .clk            (clk),
    .rst            (rst),
    .i_stall        (w_perf_stall),
    .i_redirect     (w_redirect),
    .o_stall_cycles (perf_stall_cycles),
    .o_redirects    (perf_redirects)
  );
`else
  assign perf_stall_cycles = '0;
  assign perf_redirects    = '0;
`endif
endmodule

// File: doc/pc_flow_ctrl.md
Name: pc_flow_ctrl

Overview:
- Sequencing controller for the fetch-stage program counter.
- Each cycle it decides whether the PC advances, holds, or redirects. It drives the PC select code (PC_IF / PC_EX / PC_REG, from constants.sv) and the PC enable.
- It also generates pipeline-register flush/stall strobes for IF/ID and ID/EX.
- Sits beside the PC in the fetch stage. Consumes hazard, branch-resolution and instruction-memory status from the decode, execute and memory interfaces.

Parameters:
- BOOT_CYCLES, 4: cycles after reset with PC frozen and pipeline flushed (memory settle).
- STALL_TIMEOUT, 255: consecutive imem-not-ready cycles before a fatal halt. Legal range 1..255.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- branch_taken_ex  input  1  conditional branch in EX resolved taken.
- jal_ex  input  1  JAL in EX.
- jalr_ex  input  1  JALR in EX.
- halt_ex  input  1  ECALL/EBREAK or illegal instruction reached EX.
- load_use  input  1  load-use hazard detected in ID.
- imem_ready  input  1  instruction memory returns data this cycle.
- pc_mux  output  2  PC select code: PC_IF, PC_EX or PC_REG.
- pc_en  output  1  PC update enable.
- fetch_valid  output  1  instruction entering IF/ID this cycle is valid.
- stall_if_id  output  1  hold IF/ID contents.
- flush_if_id  output  1  clear IF/ID to bubble.
- flush_id_ex  output  1  clear ID/EX to bubble.
- halted  output  1  core halted.
- timeout_err  output  1  halt caused by imem timeout (sticky).
- perf_stall_cycles  output  32  see Optional Feature.
- perf_redirects  output  32  see Optional Feature.

Behaviour:
- FSM states: BOOT, RUN, HALT. Outputs are Mealy: decoded combinationally from state and current inputs.
- Reset (rst=1 at posedge):
  - State BOOT, boot counter=0, stall counter=0, timeout_err=0.
  - While in BOOT: pc_en=0, pc_mux=PC_IF, flush_if_id=1, flush_id_ex=1, stall_if_id=0, fetch_valid=0, halted=0.
  - rst mid-operation (any state) gives the same result on the next cycle.
- BOOT:
  - Boot counter increments each cycle.
  - After BOOT_CYCLES cycles in BOOT, go to RUN.
  - All non-reset inputs are ignored.
- RUN, strict priority, evaluated each cycle:
  1. halt_ex: pc_en=0, flush_if_id=1, flush_id_ex=1. Next state HALT.
  2. jalr_ex: pc_mux=PC_REG, pc_en=1, flush_if_id=1, flush_id_ex=1, fetch_valid=0.
  3. branch_taken_ex or jal_ex: pc_mux=PC_EX, pc_en=1, flushes as in (2).
  4. load_use: pc_en=0, stall_if_id=1, flush_id_ex=1 (bubble), fetch_valid=0.
  5. !imem_ready: pc_en=0, stall_if_id=1, flush_id_ex=0, fetch_valid=0. Stall counter increments.
  6. Otherwise: pc_mux=PC_IF, pc_en=1, fetch_valid=1.
- Redirect (2/3) overrides a simultaneous load_use or !imem_ready. The stall is discarded, because the stalled instruction is on the wrong path.
- jalr_ex together with branch_taken_ex: PC_REG wins.
- Stall counter:
  - 8-bit; clears on any cycle where imem_ready=1 or a redirect is taken.
  - When it reaches STALL_TIMEOUT: timeout_err←1 and next state HALT.
- HALT:
  - pc_en=0, halted=1, flush_if_id=1, flush_id_ex=1.
  - Exits only via rst.
- pc_mux=PC_IF whenever not redirecting (including when pc_en=0). There is no X propagation on pc_mux.

Optional Feature:
- Macro: PC_FLOW_CTRL_PERF_EN.
- Defined:
  - perf_stall_cycles counts RUN cycles with pc_en=0 and no halt.
  - perf_redirects counts taken redirects.
  - Both are 32-bit, wrap at 2^32, and clear on rst.
- Undefined: both ports are tied to 0 and no counter flops are instantiated.

Decomposition:
- Package pc_flow_pkg holds:
  - state enum (BOOT, RUN, HALT);
  - STALL_CNT_W=8;
  - perf counter width.
- PC_IF/PC_EX/PC_REG stay in constants.sv and are reused unchanged.
- One natural sub-module: pc_flow_perf (the two saturating-free counters), instantiated only under PC_FLOW_CTRL_PERF_EN.

Test Plan:
- Boot sequence: rst for 2 cycles, then release with BOOT_CYCLES=4 → pc_en=0 and both flushes=1 for 4 cycles; pc_en=1, fetch_valid=1 on cycle 5.
- Redirect types: jalr_ex=1 → pc_mux=PC_REG, pc_en=1, both flushes=1 that cycle. branch_taken_ex=1 with load_use=1 → pc_mux=PC_EX, pc_en=1, stall_if_id=0.
- Load-use bubble: load_use=1 for 1 cycle → pc_en=0, stall_if_id=1, flush_id_ex=1. Next cycle normal fetch with pc_mux=PC_IF.
- Imem timeout: imem_ready=0 with STALL_TIMEOUT=3 → 3 stall cycles, then halted=1, timeout_err=1. A later imem_ready=1 does not resume. rst clears both flags.
- Halt in EX: halt_ex=1 together with jal_ex=1 → pc_en=0, next cycle halted=1. Reset asserted in HALT → BOOT restart.
- With PC_FLOW_CTRL_PERF_EN: 2 load_use cycles + 1 redirect → perf_stall_cycles=2, perf_redirects=1. Without the macro, both read 0.
